// File: rtl/q_mul_pipe.sv
// Pipelined signed fixed-point multiplier.
// Stage 1 forms the full-width product. Any middle stages only carry it forward.
// The final stage rounds, saturates and registers the narrowed result.
// A single global advance stalls every stage together under backpressure.
module q_mul_pipe #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 8,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_sat,
    output logic [15:0]      sat_count,
    input  logic             clr_sat
);

    localparam int PW = 2 * WIDTH;

    // Mask selecting the fractional bits that are dropped by the final shift.
    localparam logic [PW-1:0] FRAC_MASK = (PW'(1) << FRAC) - PW'(1);

    // Weight of the most significant dropped bit. This is the "exactly half" point.
    localparam logic [PW-1:0] HALF_LSB = (PW'(1) << FRAC) >> 1;

    // Saturation limits, sign-extended to the width of the rounded value.
    localparam logic signed [PW:0] MAX_VAL =
        $signed({{(PW - WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}});
    localparam logic signed [PW:0] MIN_VAL =
        $signed({{(PW - WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}});

    logic                 advance;
    logic signed [PW-1:0] product;
    logic signed [PW-1:0] final_prod;
    logic [1:0]           final_rnd;
    logic                 final_valid;
    logic signed [PW-1:0] shifted;
    logic [PW-1:0]        frac_bits;
    logic                 round_up;
    logic signed [PW:0]   rounded;
    logic [WIDTH-1:0]     sat_result;
    logic                 sat_flag;

    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    // Both operands are explicitly sign-extended.
    // This makes the multiply produce the full 2*WIDTH-bit signed product.
    assign product = $signed({{WIDTH{in_a[WIDTH-1]}}, in_a}) *
                     $signed({{WIDTH{in_b[WIDTH-1]}}, in_b});

    generate
        if (STAGES == 1) begin : g_single
            assign final_prod  = product;
            assign final_rnd   = in_rnd;
            assign final_valid = in_valid;
        end else begin : g_multi
            logic signed [PW-1:0] prod_pipe [STAGES-1];
            logic [1:0]           rnd_pipe  [STAGES-1];
            logic [STAGES-2:0]    valid_pipe;

            // Product stages shift together on advance and hold everything otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_pipe <= '0;
                    for (int i = 0; i < STAGES - 1; i++) begin
                        prod_pipe[i] <= '0;
                        rnd_pipe[i]  <= '0;
                    end
                end else if (advance) begin
                    valid_pipe[0] <= in_valid;
                    prod_pipe[0]  <= product;
                    rnd_pipe[0]   <= in_rnd;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        valid_pipe[i] <= valid_pipe[i-1];
                        prod_pipe[i]  <= prod_pipe[i-1];
                        rnd_pipe[i]   <= rnd_pipe[i-1];
                    end
                end
            end

            assign final_prod  = prod_pipe[STAGES-2];
            assign final_rnd   = rnd_pipe[STAGES-2];
            assign final_valid = valid_pipe[STAGES-2];
        end
    endgenerate

    // Round the full product, then clamp it to the WIDTH-bit signed range.
    always_comb begin
        shifted   = final_prod >>> FRAC;
        frac_bits = final_prod & FRAC_MASK;
        round_up  = 1'b0;
        if (FRAC != 0) begin
            case (final_rnd)
                2'b00:   round_up = 1'b0;
                2'b10:   round_up = (frac_bits > HALF_LSB) ||
                                    ((frac_bits == HALF_LSB) && shifted[0]);
                default: round_up = (frac_bits >= HALF_LSB);
            endcase
        end
        rounded = $signed({shifted[PW-1], shifted}) + $signed({{PW{1'b0}}, round_up});
        if (rounded > MAX_VAL) begin
            sat_result = {1'b0, {(WIDTH - 1){1'b1}}};
            sat_flag   = 1'b1;
        end else if (rounded < MIN_VAL) begin
            sat_result = {1'b1, {(WIDTH - 1){1'b0}}};
            sat_flag   = 1'b1;
        end else begin
            sat_result = rounded[WIDTH-1:0];
            sat_flag   = 1'b0;
        end
    end

    // The output register is the last pipeline stage. It holds steady while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_sat    <= 1'b0;
        end else if (advance) begin
            out_valid  <= final_valid;
            out_result <= sat_result;
            out_sat    <= final_valid && sat_flag;
        end
    end

    // Count saturated results as they are consumed.
    // The count sticks at all-ones, and a clear overrides a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (clr_sat) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: doc/q_mul_pipe.md
Q_MUL_PIPE -- requirements
Module: q_mul_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clk and rst_n are its only clock and reset ports.
REQ-002 Parameters SHALL be (name, default, meaning):
- WIDTH, 16: operand and result width, signed two's complement, range 4..32.
- FRAC, 8: fractional bits, range 0..WIDTH-1.
- STAGES, 3: pipeline depth, range 1..4.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: async active-low reset.
- in_valid, in, 1: operand beat valid.
- in_ready, out, 1: block accepts a beat.
- in_a, in, WIDTH: signed operand A.
- in_b, in, WIDTH: signed operand B.
- in_rnd, in, 2: rounding mode for this beat.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- out_result, out, WIDTH: signed Q(WIDTH-FRAC).FRAC product.
- out_sat, out, 1: this result was saturated.
- sat_count, out, 16: count of saturated results accepted downstream.
- clr_sat, in, 1: synchronous clear of sat_count.

Function
REQ-004 A beat SHALL be accepted when in_valid && in_ready; a result SHALL be consumed when out_valid && out_ready.
REQ-005 Pipeline advance SHALL be advance = out_ready || !out_valid, and in_ready SHALL equal advance, combinationally.
REQ-006 On advance, every stage SHALL shift one position and stage 1 SHALL load the input beat (valid = in_valid); without advance, all stages SHALL hold, including data and valid bits.
REQ-007 Latency with no stall SHALL be exactly STAGES cycles from acceptance to out_valid; throughput SHALL be one beat per cycle.
REQ-008 Results SHALL emerge in acceptance order, with no loss and no duplication; bubbles are not collapsed.
REQ-009 out_result, out_sat and out_valid SHALL be driven from registers, and SHALL stay stable while out_valid && !out_ready.
REQ-010 The product SHALL be the full 2*WIDTH-bit signed product of in_a and in_b, with no intermediate truncation.
REQ-011 Rounding SHALL be selected by in_rnd, captured with the beat:
- 00: truncate, i.e. arithmetic shift right by FRAC, rounding toward minus infinity.
- 01: round half up, i.e. add 2^(FRAC-1) then arithmetic shift.
- 10: convergent, round half to even.
- 11: treated as 01.
REQ-012 With FRAC=0, all modes SHALL pass the product through unrounded.
REQ-013 Saturation SHALL be evaluated on the full-width rounded value before narrowing to WIDTH:
- Above 2^(WIDTH-1)-1: result is 2^(WIDTH-1)-1 and out_sat=1.
- Below -2^(WIDTH-1): result is -2^(WIDTH-1) and out_sat=1.
- Otherwise: result is the low WIDTH bits and out_sat=0.
REQ-014 Arithmetic SHALL be split across the stages as follows:
- STAGES>=2: multiply in stage 1, round/saturate in the final stage.
- STAGES=1: all arithmetic in one stage.
REQ-015 sat_count SHALL increment by 1 on each consumed result with out_sat=1, and SHALL hold at 16'hFFFF rather than wrap.
REQ-016 clr_sat SHALL clear sat_count to 0 on the next edge; if it coincides with an increment, clear SHALL win and the result SHALL be 0.

Reset
REQ-017 While rst_n=0, outputs SHALL reset asynchronously as follows:
- All stage valid bits, out_valid and out_sat: 0.
- out_result: 0.
- sat_count: 0.
- in_ready: 1, since !out_valid.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight beats; no result from before reset SHALL appear after release.
REQ-019 After rst_n deasserts, the first acceptance SHALL occur no earlier than the first rising clk edge.

Verification (WIDTH=16, FRAC=8, STAGES=3)
REQ-020 Basic product: a=0x0180, b=0x0200, rnd=00 -> out_result=0x0300, out_sat=0, out_valid exactly 3 cycles after acceptance.
REQ-021 Rounding, a=0x0003, b=0x0080:
- rnd 00 -> 0x0001.
- rnd 01 -> 0x0002.
- rnd 10 -> 0x0002.
REQ-022 Negative rounding, a=0xFFFF, b=0x0080:
- rnd 00 -> 0xFFFF.
- rnd 01 -> 0x0000.
- rnd 10 -> 0x0000.
REQ-023 Saturation:
- a=0x7FFF, b=0x7FFF -> 0x7FFF, sat=1.
- a=0x8000, b=0x8000 -> 0x7FFF, sat=1.
- a=0x8000, b=0x7FFF -> 0x8000, sat=1.
- sat_count=3 after all three are consumed.
- clr_sat pulsed together with a 4th saturating consume -> sat_count=0.
REQ-024 Backpressure: stream 8 beats with out_ready low for cycles 4-9 -> in_ready low while out_valid && !out_ready; all 8 results in order; outputs stable during the stall.
REQ-025 Reset mid-stream: assert rst_n with 3 beats in flight -> out_valid=0 immediately, sat_count=0; no stale result after release.
